// File: rtl/pulse_peak_detector.sv
// Turns shaped filter pulses into events (peak, peak time, time-over-threshold, flags) behind a valid/ready port.
// Optional pile-up detection is built when PPD_PILEUP_EN is defined.
`timescale 1ns/1ps
module pulse_peak_detector #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned TIME_W    = 16,
    parameter int unsigned WIDTH_W   = 8,
    parameter int unsigned MAX_WIDTH = 200,
    parameter int unsigned HYST      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  input_data,
    input  logic [DATA_W-1:0]  threshold,
    input  logic               event_ready,
    output logic               event_valid,
    output logic [DATA_W-1:0]  event_peak,
    output logic [TIME_W-1:0]  event_time,
    output logic [WIDTH_W-1:0] event_width,
    output logic [1:0]         event_flags,
    output logic [7:0]         lost_count
);

    typedef enum logic [1:0] {IDLE, RISE, FALL, HOLDOFF} state_t;

    localparam logic [WIDTH_W-1:0] MAX_W = WIDTH_W'(MAX_WIDTH);

    state_t             state, state_nxt;
    logic [TIME_W-1:0]  ts;
    logic [DATA_W-1:0]  thr_q;
    logic [DATA_W-1:0]  peak, peak_nxt;
    logic [TIME_W-1:0]  ptime, ptime_nxt;
    logic [WIDTH_W-1:0] width, width_nxt, width_inc;
    logic               above;
    logic               close;
    logic               close_to;
    logic               pile_flag;

`ifdef PPD_PILEUP_EN
    localparam logic [DATA_W:0] HYST_X = (DATA_W+1)'(HYST);
    logic [DATA_W-1:0] valley, valley_nxt;
    logic              pile, pile_nxt;
    assign pile_flag = pile_nxt;
`else
    assign pile_flag = 1'b0;
`endif

    assign above     = input_data > thr_q;
    assign width_inc = (width == '1) ? width : width + WIDTH_W'(1);

    always_comb begin
        state_nxt = state;
        peak_nxt  = peak;
        ptime_nxt = ptime;
        width_nxt = width;
        close     = 1'b0;
        close_to  = 1'b0;
`ifdef PPD_PILEUP_EN
        valley_nxt = valley;
        pile_nxt   = pile;
`endif
        case (state)
            IDLE: begin
                if (above) begin
                    state_nxt = RISE;
                    peak_nxt  = input_data;
                    ptime_nxt = ts;
                    width_nxt = WIDTH_W'(1);
`ifdef PPD_PILEUP_EN
                    valley_nxt = input_data;
                    pile_nxt   = 1'b0;
`endif
                end
            end
            RISE, FALL: begin
                if (!above) begin
                    close     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    if (input_data > peak) begin
                        peak_nxt  = input_data;
                        ptime_nxt = ts;
                    end
                    width_nxt = width_inc;
`ifdef PPD_PILEUP_EN
                    // RISE watches for a real drop off the peak; FALL tracks the valley and flags a re-rise.
                    if (state == RISE) begin
                        if (({1'b0, input_data} + HYST_X) < {1'b0, peak}) begin
                            state_nxt  = FALL;
                            valley_nxt = input_data;
                        end
                    end else begin
                        if (input_data < valley)
                            valley_nxt = input_data;
                        if ({1'b0, input_data} > ({1'b0, valley} + HYST_X)) begin
                            pile_nxt  = 1'b1;
                            state_nxt = RISE;
                        end
                    end
`endif
                    if (width_inc == MAX_W) begin
                        close     = 1'b1;
                        close_to  = 1'b1;
                        state_nxt = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                if (!above)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ts    <= '0;
            thr_q <= '0;
            peak  <= '0;
            ptime <= '0;
            width <= '0;
`ifdef PPD_PILEUP_EN
            valley <= '0;
            pile   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            ts    <= ts + TIME_W'(1);
            if (state == IDLE)
                thr_q <= threshold;
            peak  <= peak_nxt;
            ptime <= ptime_nxt;
            width <= width_nxt;
`ifdef PPD_PILEUP_EN
            valley <= valley_nxt;
            pile   <= pile_nxt;
`endif
        end
    end

    // 1-deep holding register: a close lands only if the slot is empty or draining this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_valid <= 1'b0;
            event_peak  <= '0;
            event_time  <= '0;
            event_width <= '0;
            event_flags <= '0;
            lost_count  <= '0;
        end else if (close) begin
            if (!event_valid || event_ready) begin
                event_valid <= 1'b1;
                event_peak  <= peak_nxt;
                event_time  <= ptime_nxt;
                event_width <= width_nxt;
                event_flags <= {pile_flag, close_to};
            end else if (lost_count != '1) begin
                lost_count <= lost_count + 8'd1;
            end
        end else if (event_valid && event_ready) begin
            event_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed bench for pulse_peak_detector; honours PPD_PILEUP_EN for the pile-up expectation.
`timescale 1ns/1ps
module tb_pulse_peak_detector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] input_data = '0;
    logic [15:0] threshold = '0;
    logic        event_ready = 1'b0;

    logic        event_valid;
    logic [15:0] event_peak;
    logic [15:0] event_time;
    logic [7:0]  event_width;
    logic [1:0]  event_flags;
    logic [7:0]  lost_count;

    logic        w_valid;
    logic [15:0] w_peak;
    logic [3:0]  w_time;
    logic [7:0]  w_width;
    logic [1:0]  w_flags;
    logic [7:0]  w_lost;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int ncyc   = 0;

`ifdef PPD_PILEUP_EN
    localparam logic [1:0] PILE_EXP = 2'b10;
`else
    localparam logic [1:0] PILE_EXP = 2'b00;
`endif

    pulse_peak_detector #(.DATA_W(16), .TIME_W(16), .WIDTH_W(8), .MAX_WIDTH(200), .HYST(8)) dut (
        .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
        .event_ready(event_ready), .event_valid(event_valid), .event_peak(event_peak),
        .event_time(event_time), .event_width(event_width), .event_flags(event_flags),
        .lost_count(lost_count)
    );

    pulse_peak_detector #(.DATA_W(16), .TIME_W(4), .WIDTH_W(8), .MAX_WIDTH(200), .HYST(8)) dut_w (
        .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
        .event_ready(event_ready), .event_valid(w_valid), .event_peak(w_peak),
        .event_time(w_time), .event_width(w_width), .event_flags(w_flags),
        .lost_count(w_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [15:0] d);
        @(negedge clk);
        input_data = d;
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    initial begin
        int nvalid;
        int first_idx;
        logic [15:0] to_peak;
        logic [15:0] to_time;
        logic [7:0]  to_width;
        logic [1:0]  to_flags;
        logic        trig;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", event_valid, 0);
        chk("rst_peak",  event_peak, 0);
        chk("rst_time",  event_time, 0);
        chk("rst_width", event_width, 0);
        chk("rst_flags", event_flags, 0);
        chk("rst_lost",  lost_count, 0);
        threshold   = 16'd100;
        event_ready = 1'b1;
        reset = 1'b0;
        ncyc  = 0;

        // isolated pulse: ts 0..6 = 0,0,50,150,400,300,90
        step(0); step(0); step(50); step(150); step(400); step(300);
        chk("iso_pre_valid", event_valid, 0);
        step(90);
        chk("iso_valid", event_valid, 1);
        chk("iso_peak",  event_peak, 400);
        chk("iso_time",  event_time, 4);
        chk("iso_width", event_width, 3);
        chk("iso_flags", event_flags, 0);
        step(0);
        chk("iso_drop", event_valid, 0);

        // back-pressure: pulse at ts 8..10, second pulse at ts 28..29
        event_ready = 1'b0;
        step(200); step(300); step(50);
        chk("bp_valid", event_valid, 1);
        chk("bp_peak",  event_peak, 300);
        chk("bp_time",  event_time, 9);
        chk("bp_width", event_width, 2);
        for (int i = 0; i < 17; i++) begin
            step(0);
            chk("bp_hold", {event_valid, event_peak}, {1'b1, 16'd300});
        end
        step(500); step(50);
        chk("bp_lost",   lost_count, 1);
        chk("bp_valid2", event_valid, 1);
        chk("bp_peak2",  event_peak, 300);
        chk("bp_time2",  event_time, 9);
        chk("bp_width2", event_width, 2);
        event_ready = 1'b1;
        step(0);
        chk("bp_xfer", event_valid, 0);

        // timeout: 500 from ts 31 for 300 cycles
        nvalid = 0; first_idx = -1;
        to_peak = '0; to_time = '0; to_width = '0; to_flags = '0;
        for (int i = 0; i < 300; i++) begin
            step(500);
            if (event_valid) begin
                if (nvalid == 0) begin
                    first_idx = i;
                    to_peak = event_peak; to_time = event_time;
                    to_width = event_width; to_flags = event_flags;
                end
                nvalid++;
            end
        end
        chk("to_count", nvalid, 1);
        chk("to_index", first_idx, 199);
        chk("to_peak",  to_peak, 500);
        chk("to_time",  to_time, 31);
        chk("to_width", to_width, 200);
        chk("to_flags", to_flags, 1);
        step(50);
        chk("to_release", event_valid, 0);
        step(0);

        // pile-up: ts 333..337 = 150,400,200,300,50
        step(150); step(400); step(200); step(300); step(50);
        chk("pile_valid", event_valid, 1);
        chk("pile_peak",  event_peak, 400);
        chk("pile_time",  event_time, 334);
        chk("pile_width", event_width, 4);
        chk("pile_flags", event_flags, PILE_EXP);
        step(0);

        // wrap and equality: samples equal to threshold never trigger
        trig = 1'b0;
        step(100);
        trig = trig | event_valid;
        while ((ncyc % 16) != 15) begin
            step(100);
            trig = trig | event_valid;
        end
        chk("eq_no_trig", trig, 0);
        chk("wrap_align", ncyc, 351);
        step(300); step(50);
        chk("wrap1_valid", w_valid, 1);
        chk("wrap1_time",  w_time, 15);
        chk("wrap1_width", w_width, 1);
        chk("wrap1_peak",  w_peak, 300);
        chk("wrap1_full",  event_time, 351);
        step(250);
        chk("wrap_gap", event_valid, 0);
        step(50);
        chk("wrap2_valid", w_valid, 1);
        chk("wrap2_time",  w_time, 1);
        chk("wrap2_peak",  w_peak, 250);
        chk("wrap2_width", w_width, 1);
        chk("wrap2_flags", w_flags, 0);
        chk("wrap2_lost",  w_lost, 1);
        chk("wrap2_full",  event_time, 353);
        step(0);

        // async reset in RISE while an event is held
        event_ready = 1'b0;
        step(300); step(50);
        chk("mid_valid", event_valid, 1);
        chk("mid_lost",  lost_count, 1);
        step(400);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", event_valid, 0);
        chk("mid_rst_peak",  event_peak, 0);
        chk("mid_rst_time",  event_time, 0);
        chk("mid_rst_width", event_width, 0);
        chk("mid_rst_flags", event_flags, 0);
        chk("mid_rst_lost",  lost_count, 0);
        input_data = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ncyc  = 0;
        event_ready = 1'b1;
        step(0); step(0); step(150); step(250); step(0);
        chk("post_valid", event_valid, 1);
        chk("post_peak",  event_peak, 250);
        chk("post_time",  event_time, 3);
        chk("post_width", event_width, 2);
        chk("post_flags", event_flags, 0);
        chk("post_lost",  lost_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
